ctrl_pipe: RTL and testbench

- Pipelined successor to the combinational opcode decoder.
- Decodes the ID-stage instruction, then carries its control bundle through EX, MEM and WB registers.
- Adds a load-use interlock, branch flush, external stall, and halt drain.
- Sits between the fetch/decode front end and the datapath stage muxes.

---
 rtl/ctrl_pipe.sv | 256 +++++++++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: decodes the ID-stage instruction and carries its control bundle
// through EX, MEM and WB registers. Adds a load-use interlock, branch flush,
// an external freeze and a halt drain in front of the datapath stage muxes.
module ctrl_pipe #(
  parameter int  REG_AW    = 4,
  parameter int  HAZARD_EN = 1,
  parameter int  ZERO_REG  = 1,
  localparam int INSTR_W   = 4 + 3 * REG_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  input  logic               stall_in,
  input  logic               flush,
  output logic               instr_ready,
  output logic               id_regsrc,
  output logic               id_branch,
  output logic               id_branchsrc,
  output logic [1:0]         id_immsize,
  output logic               ex_valid,
  output logic               ex_alusrc,
  output logic [1:0]         ex_immsize,
  output logic [1:0]         ex_datasrc,
  output logic               mem_valid,
  output logic               mem_memop,
  output logic               mem_memwrite,
  output logic               wb_valid,
  output logic               wb_regwrite,
  output logic [REG_AW-1:0]  wb_rd,
  output logic [1:0]         wb_datasrc,
  output logic               hlt
);

  typedef struct packed {
    logic       regsrc;
    logic       branch;
    logic       branchsrc;
    logic [1:0] immsize;
    logic       alusrc;
    logic       memop;
    logic       memwrite;
    logic       regwrite;
    logic [1:0] datasrc;
    logic       halt;
  } ctl_t;

  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_LHB = 4'b1010;
  localparam logic [3:0] OP_LLB = 4'b1011;
  localparam logic [3:0] OP_BR  = 4'b1101;

  // Opcode to control bundle; anything not set stays 0.
  function automatic ctl_t decode(input logic [3:0] op);
    ctl_t c;
    c = '0;
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111: begin
        c.regwrite = 1'b1;
        c.datasrc  = 2'b11;
      end
      4'b0100, 4'b0101, 4'b0110: begin
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.datasrc  = 2'b11;
      end
      4'b1000: begin
        c.regwrite = 1'b1;
        c.memop    = 1'b1;
        c.alusrc   = 1'b1;
        c.datasrc  = 2'b00;
      end
      4'b1001: begin
        c.regsrc   = 1'b1;
        c.memop    = 1'b1;
        c.memwrite = 1'b1;
        c.alusrc   = 1'b1;
      end
      4'b1010: begin
        c.regsrc   = 1'b1;
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.immsize  = 2'b11;
        c.datasrc  = 2'b10;
      end
      4'b1011: begin
        c.regsrc   = 1'b1;
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.immsize  = 2'b10;
        c.datasrc  = 2'b10;
      end
      4'b1100: begin
        c.branch  = 1'b1;
        c.immsize = 2'b01;
      end
      4'b1101: begin
        c.branch    = 1'b1;
        c.branchsrc = 1'b1;
      end
      4'b1110: begin
        c.regwrite = 1'b1;
        c.datasrc  = 2'b01;
      end
      4'b1111: c.halt = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic uses_f1(input logic [3:0] op);
    return (op == OP_SW) || (op == OP_LHB) || (op == OP_LLB);
  endfunction

  function automatic logic uses_f2(input logic [3:0] op);
    return !op[3] || (op == OP_LW) || (op == OP_SW) || (op == OP_BR);
  endfunction

  function automatic logic uses_f3(input logic [3:0] op);
    return (op == 4'b0000) || (op == 4'b0001) || (op == 4'b0010) ||
           (op == 4'b0011) || (op == 4'b0111);
  endfunction

  // A read of the register being loaded; r0 is exempt when it is hard-wired.
  function automatic logic src_hit(input logic used,
                                   input logic [REG_AW-1:0] src,
                                   input logic [REG_AW-1:0] rd);
    return used && (src == rd) && !((ZERO_REG != 0) && (src == '0));
  endfunction

  logic [3:0]        id_op;
  logic [REG_AW-1:0] id_f1, id_f2, id_f3;
  ctl_t              id_ctl;
  logic              ex_is_lw;
  logic              hazard;
  logic              load_ex;
  logic              halting;
  logic              hlt_q;

  logic              vld_p0, alusrc_p0, memop_p0, memwrite_p0, regwrite_p0, halt_p0;
  logic [1:0]        immsize_p0, datasrc_p0;
  logic [REG_AW-1:0] rd_p0;

  logic              vld_p1, memop_p1, memwrite_p1, regwrite_p1, halt_p1;
  logic [1:0]        datasrc_p1;
  logic [REG_AW-1:0] rd_p1;

  logic              vld_p2, regwrite_p2;
  logic [1:0]        datasrc_p2;
  logic [REG_AW-1:0] rd_p2;

  assign id_op = instr[INSTR_W-1 -: 4];
  assign id_f1 = instr[3*REG_AW-1:2*REG_AW];
  assign id_f2 = instr[2*REG_AW-1:REG_AW];
  assign id_f3 = instr[REG_AW-1:0];

  assign ex_is_lw = vld_p0 && memop_p0 && !memwrite_p0;

  // ID decode and load-use detection against the load sitting in EX.
  always_comb begin
    id_ctl = '0;
    hazard = 1'b0;
    if (instr_valid) begin
      id_ctl = decode(id_op);
      if ((HAZARD_EN != 0) && ex_is_lw) begin
        hazard = src_hit(uses_f1(id_op), id_f1, rd_p0) ||
                 src_hit(uses_f2(id_op), id_f2, rd_p0) ||
                 src_hit(uses_f3(id_op), id_f3, rd_p0);
      end
    end
  end

  // Flush outranks the interlock and halt: the ID instruction is consumed and dropped.
  assign load_ex     = instr_valid && !flush && !hazard && !halting;
  assign instr_ready = !stall_in && (flush || (!hazard && !halting));

  // ---- ID -> EX -> MEM -> WB control registers (frozen while stall_in) ----
  // Control state: reset clears everything, stall_in holds, else shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0      <= 1'b0;
      alusrc_p0   <= 1'b0;
      immsize_p0  <= 2'b00;
      datasrc_p0  <= 2'b00;
      memop_p0    <= 1'b0;
      memwrite_p0 <= 1'b0;
      regwrite_p0 <= 1'b0;
      halt_p0     <= 1'b0;
      vld_p1      <= 1'b0;
      memop_p1    <= 1'b0;
      memwrite_p1 <= 1'b0;
      regwrite_p1 <= 1'b0;
      datasrc_p1  <= 2'b00;
      halt_p1     <= 1'b0;
      vld_p2      <= 1'b0;
      regwrite_p2 <= 1'b0;
      datasrc_p2  <= 2'b00;
      halting     <= 1'b0;
      hlt_q       <= 1'b0;
    end else if (!stall_in) begin
      vld_p0      <= load_ex;
      alusrc_p0   <= load_ex && id_ctl.alusrc;
      immsize_p0  <= load_ex ? id_ctl.immsize : 2'b00;
      datasrc_p0  <= load_ex ? id_ctl.datasrc : 2'b00;
      memop_p0    <= load_ex && id_ctl.memop;
      memwrite_p0 <= load_ex && id_ctl.memwrite;
      regwrite_p0 <= load_ex && id_ctl.regwrite;
      halt_p0     <= load_ex && id_ctl.halt;
      // ---- EX -> MEM ----
      vld_p1      <= vld_p0;
      memop_p1    <= memop_p0;
      memwrite_p1 <= memwrite_p0;
      regwrite_p1 <= regwrite_p0;
      datasrc_p1  <= datasrc_p0;
      halt_p1     <= halt_p0;
      // ---- MEM -> WB ----
      vld_p2      <= vld_p1;
      regwrite_p2 <= regwrite_p1;
      datasrc_p2  <= datasrc_p1;
      if (load_ex && id_ctl.halt) halting <= 1'b1;
      if (vld_p1 && halt_p1)      hlt_q   <= 1'b1;
    end
  end

  // Destination register travels with the entry; it is only observed when valid.
  always_ff @(posedge clk) begin
    if (!stall_in) begin
      rd_p0 <= id_f1;
      rd_p1 <= rd_p0;
      rd_p2 <= rd_p1;
    end
  end

  assign id_regsrc    = id_ctl.regsrc;
  assign id_branch    = id_ctl.branch;
  assign id_branchsrc = id_ctl.branchsrc;
  assign id_immsize   = id_ctl.immsize;

  assign ex_valid     = vld_p0;
  assign ex_alusrc    = vld_p0 && alusrc_p0;
  assign ex_immsize   = vld_p0 ? immsize_p0 : 2'b00;
  assign ex_datasrc   = vld_p0 ? datasrc_p0 : 2'b00;

  assign mem_valid    = vld_p1;
  assign mem_memop    = vld_p1 && memop_p1;
  assign mem_memwrite = vld_p1 && memwrite_p1;

  assign wb_valid     = vld_p2;
  assign wb_regwrite  = vld_p2 && regwrite_p2 && !((ZERO_REG != 0) && (rd_p2 == '0));
  assign wb_rd        = vld_p2 ? rd_p2 : '0;
  assign wb_datasrc   = vld_p2 ? datasrc_p2 : 2'b00;

  assign hlt          = hlt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed stimulus with a WB scoreboard plus cycle checks.
module tb_ctrl_pipe;

  typedef struct packed {
    logic       rw;
    logic [3:0] rd;
    logic [1:0] ds;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, instr_valid, stall_in, flush;
  logic [15:0] instr;

  logic       instr_ready, id_regsrc, id_branch, id_branchsrc;
  logic [1:0] id_immsize;
  logic       ex_valid, ex_alusrc;
  logic [1:0] ex_immsize, ex_datasrc;
  logic       mem_valid, mem_memop, mem_memwrite;
  logic       wb_valid, wb_regwrite;
  logic [3:0] wb_rd;
  logic [1:0] wb_datasrc;
  logic       hlt;

  logic       nh_instr_ready, nh_id_regsrc, nh_id_branch, nh_id_branchsrc;
  logic [1:0] nh_id_immsize;
  logic       nh_ex_valid, nh_ex_alusrc;
  logic [1:0] nh_ex_immsize, nh_ex_datasrc;
  logic       nh_mem_valid, nh_mem_memop, nh_mem_memwrite;
  logic       nh_wb_valid, nh_wb_regwrite;
  logic [3:0] nh_wb_rd;
  logic [1:0] nh_wb_datasrc;
  logic       nh_hlt;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  ctrl_pipe #(.REG_AW(4), .HAZARD_EN(1), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .stall_in(stall_in), .flush(flush), .instr_ready(instr_ready),
    .id_regsrc(id_regsrc), .id_branch(id_branch), .id_branchsrc(id_branchsrc),
    .id_immsize(id_immsize), .ex_valid(ex_valid), .ex_alusrc(ex_alusrc),
    .ex_immsize(ex_immsize), .ex_datasrc(ex_datasrc), .mem_valid(mem_valid),
    .mem_memop(mem_memop), .mem_memwrite(mem_memwrite), .wb_valid(wb_valid),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_datasrc(wb_datasrc), .hlt(hlt)
  );

  ctrl_pipe #(.REG_AW(4), .HAZARD_EN(0), .ZERO_REG(1)) u_nh (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .stall_in(stall_in), .flush(flush), .instr_ready(nh_instr_ready),
    .id_regsrc(nh_id_regsrc), .id_branch(nh_id_branch), .id_branchsrc(nh_id_branchsrc),
    .id_immsize(nh_id_immsize), .ex_valid(nh_ex_valid), .ex_alusrc(nh_ex_alusrc),
    .ex_immsize(nh_ex_immsize), .ex_datasrc(nh_ex_datasrc), .mem_valid(nh_mem_valid),
    .mem_memop(nh_mem_memop), .mem_memwrite(nh_mem_memwrite), .wb_valid(nh_wb_valid),
    .wb_regwrite(nh_wb_regwrite), .wb_rd(nh_wb_rd), .wb_datasrc(nh_wb_datasrc), .hlt(nh_hlt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Present an instruction until accepted; queue its WB expectation on acceptance.
  task automatic issue(input logic [15:0] ins, input exp_t e);
    int n;
    n = 0;
    instr_valid = 1'b1;
    instr       = ins;
    #1;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("issue_ready", instr_ready, 1);
    if (instr_ready) exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // WB monitor: one pop per WB entry that actually moved in on the last edge.
  initial begin
    bit   moved;
    exp_t e;
    forever begin
      @(posedge clk);
      moved = !stall_in && !rst;
      @(negedge clk);
      if (moved && wb_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL wb_unexpected: got entry rd=%0d, required none", wb_rd);
        end else begin
          e = exp_q.pop_front();
          chk("wb_regwrite", wb_regwrite, e.rw);
          chk("wb_rd", wb_rd, e.rd);
          chk("wb_datasrc", wb_datasrc, e.ds);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = 16'h0000; stall_in = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_hlt", hlt, 0);
    chk("rst_ready", instr_ready, 1);

    // ID decode while frozen so nothing is accepted.
    stall_in = 1'b1; instr_valid = 1'b1; instr = 16'hD000;
    #1;
    chk("id_br_branch", id_branch, 1);
    chk("id_br_branchsrc", id_branchsrc, 1);
    chk("id_br_regsrc", id_regsrc, 0);
    chk("stall_ready", instr_ready, 0);
    instr = 16'hA123;
    #1;
    chk("id_lhb_regsrc", id_regsrc, 1);
    chk("id_lhb_immsize", id_immsize, 3);
    instr_valid = 1'b0;
    #1;
    chk("id_invalid_regsrc", id_regsrc, 0);
    chk("id_invalid_immsize", id_immsize, 0);
    @(negedge clk);
    stall_in = 1'b0;

    // Straight-line ADD, LW, PCS.
    issue(16'h1123, '{1'b1, 4'd1, 2'b11});
    issue(16'h8412, '{1'b1, 4'd4, 2'b00});
    issue(16'hE500, '{1'b1, 4'd5, 2'b01});
    instr_valid = 1'b0;
    #1;
    chk("seq0_wb_valid", wb_valid, 1);
    chk("seq0_wb_rd", wb_rd, 1);
    chk("seq0_wb_datasrc", wb_datasrc, 3);
    @(negedge clk); #1;
    chk("seq1_wb_rd", wb_rd, 4);
    chk("seq1_wb_datasrc", wb_datasrc, 0);
    @(negedge clk); #1;
    chk("seq2_wb_rd", wb_rd, 5);
    chk("seq2_wb_datasrc", wb_datasrc, 1);
    chk("seq2_wb_regwrite", wb_regwrite, 1);
    idle(3);

    // Load-use: LW r4 then ADD r6,r4,r2.
    issue(16'h8410, '{1'b1, 4'd4, 2'b00});
    instr_valid = 1'b1; instr = 16'h0642;
    #1;
    chk("lu_ready_stall", instr_ready, 0);
    chk("nohaz_ready", nh_instr_ready, 1);
    @(negedge clk); #1;
    chk("lu_bubble_ex_valid", ex_valid, 0);
    chk("lu_ready_after", instr_ready, 1);
    exp_q.push_back('{1'b1, 4'd6, 2'b11});
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    chk("lu_add_ex_valid", ex_valid, 1);
    chk("lu_add_ex_datasrc", ex_datasrc, 3);
    idle(3);

    // Hard-wired r0: no interlock, no write-back.
    issue(16'h8010, '{1'b0, 4'd0, 2'b00});
    instr_valid = 1'b1; instr = 16'h0602;
    #1;
    chk("zr_no_stall", instr_ready, 1);
    exp_q.push_back('{1'b1, 4'd6, 2'b11});
    @(negedge clk);
    issue(16'h9314, '{1'b0, 4'd3, 2'b00});
    idle(4);

    // Flush a branch sitting in ID behind an ADD.
    issue(16'h1123, '{1'b1, 4'd1, 2'b11});
    instr_valid = 1'b1; instr = 16'hC000; flush = 1'b1;
    #1;
    chk("flush_ready", instr_ready, 1);
    chk("flush_id_branch", id_branch, 1);
    chk("flush_id_immsize", id_immsize, 1);
    chk("flush_pre_ex_valid", ex_valid, 1);
    @(negedge clk);
    flush = 1'b0; instr_valid = 1'b0;
    #1;
    chk("flush_ex_bubble", ex_valid, 0);
    chk("flush_mem_valid", mem_valid, 1);
    idle(3);

    // Freeze a full pipe with flush pending, then release.
    issue(16'h1123, '{1'b1, 4'd1, 2'b11});
    issue(16'hE500, '{1'b1, 4'd5, 2'b01});
    issue(16'hB712, '{1'b1, 4'd7, 2'b10});
    stall_in = 1'b1; flush = 1'b1; instr_valid = 1'b1; instr = 16'hC000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_ready", instr_ready, 0);
      chk("frz_ex_immsize", ex_immsize, 2);
      chk("frz_ex_alusrc", ex_alusrc, 1);
      chk("frz_mem_valid", mem_valid, 1);
      chk("frz_wb_rd", wb_rd, 1);
      @(negedge clk);
    end
    stall_in = 1'b0;
    #1;
    chk("unfrz_ready", instr_ready, 1);
    @(negedge clk);
    flush = 1'b0; instr_valid = 1'b0;
    #1;
    chk("unfrz_ex_valid", ex_valid, 0);
    chk("unfrz_mem_valid", mem_valid, 1);
    chk("unfrz_mem_memop", mem_memop, 0);
    chk("unfrz_wb_rd", wb_rd, 5);
    chk("unfrz_wb_datasrc", wb_datasrc, 1);
    idle(3);

    // Halt drain.
    issue(16'hF000, '{1'b0, 4'd0, 2'b00});
    instr_valid = 1'b1; instr = 16'h1123;
    #1;
    chk("halt_ready0", instr_ready, 0);
    chk("halt_hlt0", hlt, 0);
    @(negedge clk); #1;
    chk("halt_ready1", instr_ready, 0);
    chk("halt_hlt1", hlt, 0);
    @(negedge clk); #1;
    chk("halt_ready2", instr_ready, 0);
    chk("halt_hlt2", hlt, 1);
    @(negedge clk); #1;
    chk("halt_hlt3", hlt, 1);
    chk("halt_ex_valid", ex_valid, 0);
    @(negedge clk);
    rst = 1'b1; stall_in = 1'b1; instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; stall_in = 1'b0;
    exp_q.delete();
    #1;
    chk("halt_rst_hlt", hlt, 0);
    chk("halt_rst_ready", instr_ready, 1);
    @(negedge clk);

    // Reset with three entries in flight.
    issue(16'h1123, '{1'b1, 4'd1, 2'b11});
    issue(16'hE500, '{1'b1, 4'd5, 2'b01});
    issue(16'hB712, '{1'b1, 4'd7, 2'b10});
    rst = 1'b1; instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("mrst_ex_valid", ex_valid, 0);
    chk("mrst_mem_valid", mem_valid, 0);
    chk("mrst_wb_valid", wb_valid, 0);
    chk("mrst_ready", instr_ready, 1);
    idle(4);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
